// File: rtl/led_adc_sequencer.sv
// Front-end sequencer: alternates IR/red LED phases and serially reads an 8-bit ADC once per phase.
// Each result lands in a per-channel holding register with a one-cycle valid strobe.
module led_adc_sequencer #(
    parameter int PHASE_CYCLES  = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       CLK_Filter,
    input  logic       rst_n,
    input  logic       Run,
    input  logic       ADC_DOUT,
    output logic       ADC_CS_n,
    output logic       ADC_SCLK,
    output logic       LED_IR,
    output logic       LED_Red,
    output logic [7:0] IR_ADC_Value,
    output logic [7:0] Red_ADC_Value,
    output logic       IR_Valid,
    output logic       Red_Valid
);

    if (PHASE_CYCLES < SETTLE_CYCLES + 18 || SETTLE_CYCLES < 1) begin : g_param_check
        $error("led_adc_sequencer: PHASE_CYCLES must be >= SETTLE_CYCLES+18 and SETTLE_CYCLES >= 1");
    end

    localparam int PW = $clog2(PHASE_CYCLES);
    localparam logic [PW-1:0] P_SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST        = PW'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, STORE, HOLD} state_t;
    typedef enum logic {CH_IR, CH_RED} chan_t;

    state_t          state_q, state_d;
    chan_t           chan_q, chan_d;
    logic [PW-1:0]   p_q, p_d;
    logic [3:0]      c_q, c_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            store_ir, store_red;

    logic            cs_n_q, sclk_q, led_ir_q, led_red_q;
    logic            ir_vld_q, red_vld_q;
    logic [7:0]      ir_val_q, red_val_q;

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        p_d       = p_q + PW'(1);
        c_d       = c_q;
        shreg_d   = shreg_q;
        store_ir  = 1'b0;
        store_red = 1'b0;
        unique case (state_q)
            IDLE: begin
                p_d    = '0;
                chan_d = CH_IR;
                if (Run) state_d = SETTLE;
            end
            SETTLE: begin
                if (p_q == P_SETTLE_LAST) begin
                    state_d = CONVERT;
                    c_d     = '0;
                end
            end
            CONVERT: begin
                // Sample on the edge that ends each SCLK-high cycle; c wraps to 0 on exit.
                c_d = c_q + 4'd1;
                if (c_q[0]) shreg_d = {shreg_q[6:0], ADC_DOUT};
                if (c_q == 4'd15) state_d = STORE;
            end
            STORE: begin
                state_d   = HOLD;
                store_ir  = (chan_q == CH_IR);
                store_red = (chan_q == CH_RED);
            end
            HOLD: begin
                if (p_q == P_LAST) begin
                    p_d = '0;
                    if (Run) begin
                        state_d = SETTLE;
                        chan_d  = (chan_q == CH_IR) ? CH_RED : CH_IR;
                    end else begin
                        state_d = IDLE;
                        chan_d  = CH_IR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                p_d     = '0;
            end
        endcase
    end

    // Pin outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            chan_q    <= CH_IR;
            p_q       <= '0;
            c_q       <= '0;
            shreg_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            led_ir_q  <= 1'b0;
            led_red_q <= 1'b0;
            ir_vld_q  <= 1'b0;
            red_vld_q <= 1'b0;
            ir_val_q  <= '0;
            red_val_q <= '0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            p_q       <= p_d;
            c_q       <= c_d;
            shreg_q   <= shreg_d;
            cs_n_q    <= (state_d != CONVERT);
            sclk_q    <= (state_d == CONVERT) && c_d[0];
            led_ir_q  <= (state_d != IDLE) && (chan_d == CH_IR);
            led_red_q <= (state_d != IDLE) && (chan_d == CH_RED);
            ir_vld_q  <= store_ir;
            red_vld_q <= store_red;
            if (store_ir)  ir_val_q  <= shreg_q;
            if (store_red) red_val_q <= shreg_q;
        end
    end

    assign ADC_CS_n      = cs_n_q;
    assign ADC_SCLK      = sclk_q;
    assign LED_IR        = led_ir_q;
    assign LED_Red       = led_red_q;
    assign IR_ADC_Value  = ir_val_q;
    assign Red_ADC_Value = red_val_q;
    assign IR_Valid      = ir_vld_q;
    assign Red_Valid     = red_vld_q;

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Directed bench for led_adc_sequencer: ADC serial model, scoreboard of expected samples,
// phase/strobe timing checks, Run drop, mid-conversion reset and a short-phase instance.
module tb_led_adc_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0, run2 = 1'b0;
    logic adc_dout = 1'b0, adc_dout2 = 1'b0;

    logic       cs_n, sclk, led_ir, led_red, ir_vld, red_vld;
    logic [7:0] ir_val, red_val;
    logic       cs_n2, sclk2, led_ir2, led_red2, ir_vld2, red_vld2;
    logic [7:0] ir_val2, red_val2;

    always #5 clk = ~clk;

    led_adc_sequencer #(.PHASE_CYCLES(32), .SETTLE_CYCLES(4)) dut (
        .CLK_Filter(clk), .rst_n(rst_n), .Run(run), .ADC_DOUT(adc_dout),
        .ADC_CS_n(cs_n), .ADC_SCLK(sclk), .LED_IR(led_ir), .LED_Red(led_red),
        .IR_ADC_Value(ir_val), .Red_ADC_Value(red_val), .IR_Valid(ir_vld), .Red_Valid(red_vld)
    );

    led_adc_sequencer #(.PHASE_CYCLES(22), .SETTLE_CYCLES(4)) dut2 (
        .CLK_Filter(clk), .rst_n(rst_n), .Run(run2), .ADC_DOUT(adc_dout2),
        .ADC_CS_n(cs_n2), .ADC_SCLK(sclk2), .LED_IR(led_ir2), .LED_Red(led_red2),
        .IR_ADC_Value(ir_val2), .Red_ADC_Value(red_val2), .IR_Valid(ir_vld2), .Red_Valid(red_vld2)
    );

    typedef struct {
        logic       red;
        logic [7:0] val;
        int         due;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0, n_fail = 0, cyc = 0;
    logic [7:0] ir_word = 8'hA5, red_word = 8'hC3;
    logic [7:0] ir_word2 = 8'h5A, red_word2 = 8'h96;
    logic [7:0] exp_ir = '0, exp_red = '0;
    int led_on = -1, cs_fall = -1, sclk_cnt = 0, last_ir = -1, last_red = -1;
    logic prev_cs = 1'b1, prev_ir = 1'b0, prev_red = 1'b0;

    // ADC model: presents the next bit in the middle of each SCLK-high cycle.
    initial begin
        int k, k2;
        logic [7:0] w;
        k = 0; k2 = 0;
        forever begin
            @(negedge clk);
            if (cs_n) k = 0;
            else if (sclk && k < 8) begin
                w = led_ir ? ir_word : red_word;
                adc_dout = w[7-k];
                k++;
            end
            if (cs_n2) k2 = 0;
            else if (sclk2 && k2 < 8) begin
                w = led_ir2 ? ir_word2 : red_word2;
                adc_dout2 = w[7-k2];
                k2++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            chk("led_overlap", led_ir & led_red, 0);
            if ((prev_ir && !led_ir) || (prev_red && !led_red)) begin
                if (led_on >= 0) chk("led_width", cyc - led_on, 32);
                led_on = -1;
            end
            if ((!prev_ir && led_ir) || (!prev_red && led_red)) led_on = cyc;
            if (prev_cs && !cs_n) begin
                if (led_on >= 0) chk("cs_fall_p", cyc - led_on, 4);
                cs_fall  = cyc;
                sclk_cnt = 0;
                sb.push_back('{red: led_red, val: (led_red ? red_word : ir_word), due: cyc + 17});
            end
            if (!cs_n && sclk) sclk_cnt++;
            if (cs_n) chk("sclk_idle", sclk, 0);
            if (!prev_cs && cs_n && cs_fall >= 0) begin
                chk("cs_low_len", cyc - cs_fall, 16);
                chk("sclk_pulses", sclk_cnt, 8);
                cs_fall = -1;
            end
            if (ir_vld || red_vld) begin
                if (sb.size() == 0) chk("valid_unexpected", {ir_vld, red_vld}, 0);
                else begin
                    e = sb.pop_front();
                    chk("valid_chan", {ir_vld, red_vld}, e.red ? 2'b01 : 2'b10);
                    chk("valid_time", cyc, e.due);
                    if (e.red) begin
                        chk("red_value", red_val, e.val);
                        exp_red = e.val;
                        if (last_ir >= 0)  chk("red_lag", cyc - last_ir, 32);
                        if (last_red >= 0) chk("red_period", cyc - last_red, 64);
                        last_red = cyc;
                    end else begin
                        chk("ir_value", ir_val, e.val);
                        exp_ir = e.val;
                        if (last_ir >= 0) chk("ir_period", cyc - last_ir, 64);
                        last_ir = cyc;
                    end
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("valid_timeout", cyc, sb[0].due);
                void'(sb.pop_front());
            end
            chk("ir_hold", ir_val, exp_ir);
            chk("red_hold", red_val, exp_red);
            prev_cs  = cs_n;
            prev_ir  = led_ir;
            prev_red = led_red;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        step(3);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_leds", {led_ir, led_red}, 0);
        chk("rst_values", {ir_val, red_val}, 0);
        chk("rst_valids", {ir_vld, red_vld}, 0);

        rst_n = 1'b1;
        step(100);
        chk("idle_cs_n", cs_n, 1);
        chk("idle_leds", {led_ir, led_red}, 0);
        chk("idle_values", {ir_val, red_val}, 0);

        // Single IR conversion, then alternation with new IR word.
        run = 1'b1; last_ir = -1; last_red = -1;
        step(1);
        chk("led_ir_on", led_ir, 1);
        for (int i = 0; i < 40 && !ir_vld; i++) step(1);
        chk("ir_valid_seen", ir_vld, 1);
        chk("ir_first", ir_val, 8'hA5);
        ir_word = 8'h3C;
        step(4 * 64);
        chk("alt_ir_value", ir_val, 8'h3C);
        chk("alt_red_value", red_val, 8'hC3);

        // Drop Run at red-phase p=10.
        for (int i = 0; i < 80 && !(led_red && led_on == cyc); i++) step(1);
        chk("red_phase_found", led_red, 1);
        step(10);
        run = 1'b0;
        step(40);
        chk("drop_leds_off", {led_ir, led_red}, 0);
        chk("drop_cs_n", cs_n, 1);
        chk("drop_sb_empty", sb.size(), 0);
        step(70);
        chk("drop_stay_idle", {led_ir, led_red}, 0);
        chk("drop_ir_kept", ir_val, 8'h3C);
        chk("drop_red_kept", red_val, 8'hC3);

        // Reset in the middle of a conversion (p=12).
        run = 1'b1; last_ir = -1; last_red = -1;
        for (int i = 0; i < 5 && !led_ir; i++) step(1);
        chk("mid_led_ir", led_ir, 1);
        step(12);
        chk("mid_in_convert", cs_n, 0);
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("mid_rst_cs_n", cs_n, 1);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_leds", {led_ir, led_red}, 0);
        chk("mid_rst_values", {ir_val, red_val}, 0);
        chk("mid_rst_valids", {ir_vld, red_vld}, 0);
        sb.delete();
        exp_ir = '0; exp_red = '0; led_on = -1; cs_fall = -1;
        step(3);
        rst_n = 1'b1;
        step(10);
        chk("post_rst_idle", {led_ir, led_red, cs_n}, 3'b001);
        ir_word = 8'h69;
        run = 1'b1;
        for (int i = 0; i < 40 && !ir_vld; i++) step(1);
        chk("post_rst_valid", ir_vld, 1);
        chk("post_rst_value", ir_val, 8'h69);
        run = 1'b0;
        step(70);

        // Short-phase instance: HOLD is a single cycle at p=21.
        run2 = 1'b1;
        for (int i = 0; i < 5 && !led_ir2; i++) step(1);
        chk("p22_led_ir", led_ir2, 1);
        step(3);
        chk("p22_cs_p3", cs_n2, 1);
        step(1);
        chk("p22_cs_p4", cs_n2, 0);
        step(17);
        chk("p22_ir_valid", ir_vld2, 1);
        chk("p22_ir_value", ir_val2, 8'h5A);
        chk("p22_hold_leds", {led_ir2, led_red2}, 2'b10);
        step(1);
        chk("p22_ir_strobe_end", ir_vld2, 0);
        chk("p22_swap_leds", {led_ir2, led_red2}, 2'b01);
        step(21);
        chk("p22_red_valid", red_vld2, 1);
        chk("p22_red_value", red_val2, 8'h96);
        step(1);
        chk("p22_swap_back", {led_ir2, led_red2}, 2'b10);
        chk("p22_red_strobe_end", red_vld2, 0);
        chk("p22_ir_stable", ir_val2, 8'h5A);
        run2 = 1'b0;

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_adc_sequencer.md
# led_adc_sequencer

Front-end sequencer for the finger-clip sensor. It alternates the infrared and red LEDs and serially reads an 8-bit ADC once per LED phase. Each conversion result goes to a per-channel holding register with a one-cycle valid strobe. It supplies the IR_ADC_Value sample that the IR FIR filter consumes, and the matching red sample for the red filter path.

## Interface
- PHASE_CYCLES, 32: clock cycles per LED phase. Full IR+red period is 2*PHASE_CYCLES.
- SETTLE_CYCLES, 4: cycles after an LED switch before ADC chip-select asserts.
- Elaboration check: PHASE_CYCLES >= SETTLE_CYCLES + 18 and SETTLE_CYCLES >= 1. Otherwise elaboration fails.

Ports:
- CLK_Filter  in  1  system clock, shared with the FIR filters
- rst_n  in  1  asynchronous, active-low reset
- Run  in  1  enables sequencing; level-sensitive
- ADC_DOUT  in  1  serial ADC data, MSB first
- ADC_CS_n  out  1  ADC chip select, active low
- ADC_SCLK  out  1  ADC serial clock
- LED_IR  out  1  IR LED drive
- LED_Red  out  1  red LED drive
- IR_ADC_Value  out  8  last IR sample
- Red_ADC_Value  out  8  last red sample
- IR_Valid  out  1  one-cycle strobe: IR_ADC_Value updated
- Red_Valid  out  1  one-cycle strobe: Red_ADC_Value updated

## Operation
- All outputs are registered.
- Reset values:
  - ADC_CS_n=1; every other output 0.
  - State IDLE, phase counter p=0, channel=IR, shift register 0.
- States: IDLE, SETTLE, CONVERT, STORE, HOLD.
- IDLE:
  - LEDs off, CS_n=1.
  - Run=1 sampled → SETTLE with channel=IR, p=0, and the LED for the current channel on.
- p increments every cycle outside IDLE. LED_IR and LED_Red are never high together.
- SETTLE covers p=0..SETTLE_CYCLES-1. At p=SETTLE_CYCLES-1 → CONVERT.
- CONVERT covers p=SETTLE_CYCLES..SETTLE_CYCLES+15 (16 cycles, c=p-SETTLE_CYCLES):
  - ADC_CS_n=0 for the whole state.
  - ADC_SCLK=1 on odd c, 0 on even c.
  - At the clock edge ending each odd c, ADC_DOUT shifts into the LSB of the shift register (shift left). This gives 8 bits, MSB first.
- STORE, one cycle at p=SETTLE_CYCLES+16:
  - CS_n=1, SCLK=0.
  - The shift register is written to the current channel's value register.
  - That channel's Valid rises at the same edge.
- HOLD lasts until p=PHASE_CYCLES-1. At the next edge:
  - Run=1: channel toggles, LEDs swap, p=0 → SETTLE.
  - Run=0: LEDs off, channel=IR, p=0 → IDLE.
- Run deassertion never aborts a phase in progress. The current conversion always completes and is stored.
- Value registers hold their contents through IDLE. Only reset clears them.
- No arithmetic beyond the counters:
  - p is wide enough for PHASE_CYCLES-1.
  - The conversion bit counter wraps at 16 within CONVERT only.

## Timing
- Run high at edge 0 → LED_IR=1 from edge 1 (p=0).
- ADC_CS_n falls at p=SETTLE_CYCLES and rises at p=SETTLE_CYCLES+16.
- IR_Valid=1 and the new IR_ADC_Value are visible during p=SETTLE_CYCLES+17 (p=21 at defaults). Valid lasts exactly one cycle.
- The value stays stable until the same point in the next IR phase, 2*PHASE_CYCLES cycles later.
- LED swap at p wrap. The red phase mirrors the IR phase, so Red_Valid comes PHASE_CYCLES cycles after IR_Valid.
- Sample rate per channel: one per 2*PHASE_CYCLES cycles.
- The FIR consumes IR_ADC_Value asynchronously to the strobe; stability over a full period is guaranteed.
- Reset assertion at any point, including mid-CONVERT:
  - Immediately forces the reset values.
  - The partial shift is discarded and no Valid is issued.
  - After release, the block waits for Run in IDLE.

## Test plan
- Reset/idle: hold rst_n=0, then release with Run=0 for 100 cycles → CS_n=1, LEDs 0, values 0, no Valid.
- Single IR conversion: Run=1, ADC model returns 8'hA5 → CS_n low p=4..19; 8 SCLK pulses; IR_ADC_Value=8'hA5 with IR_Valid at p=21; LED_IR high for cycles 1..32.
- Alternation: IR model 8'h3C, red model 8'hC3, Run=1 for 4 periods:
  - Red_Valid lags IR_Valid by 32 cycles.
  - Valid strobes are 64 cycles apart per channel.
  - LEDs never overlap; values match the models.
- Run drop mid-phase: deassert Run at red-phase p=10 → red conversion completes (Red_Valid at p=21); LEDs off after p=31; IDLE; values retained.
- Reset mid-CONVERT: assert rst_n=0 at p=12 → outputs return to reset values at once; no Valid; a fresh Run yields a correct next sample.
- Parameter corner: PHASE_CYCLES=22, SETTLE_CYCLES=4 → HOLD is one cycle (p=21, Valid still high there); swap at the following edge; values correct.
